// File: rtl/tg_trace_loader.sv
// tg_trace_loader: trace prefetch stage for the trace-based traffic generator.
// Reads 32-bit packet descriptors from a synchronous trace memory (1-cycle
// read latency), buffers them in a small prefetch FIFO and hands them to a
// consumer that samples packet_out one cycle after the handshake.
//
// Build option: define TG_TRACE_LOOP_EN to replay the trace indefinitely
// (ptr/remaining reload from the latched base/count after the last read).
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no run active; waits for trace_start
// FETCH  | issuing reads while FIFO room, enable and remaining allow
// DRAIN  | all reads issued; waits for FIFO, in-flight read and pop to empty
// DONE   | trace fully delivered; done=1, trace_start re-arms
`timescale 1ns/1ps
module tg_trace_loader #(
  parameter int MEM_AW = 10,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              trace_start,
  input  logic              trace_stop,
  input  logic [MEM_AW-1:0] trace_base,
  input  logic [MEM_AW:0]   trace_count,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rd_data,
  input  logic              packet_request,
  output logic [31:0]       packet_out,
  output logic              packet_out_valid,
  output logic              done,
  output logic [15:0]       pkt_count
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW+1:0] DEPTH_W = (IW+2)'(DEPTH);
  localparam logic [MEM_AW:0] CNT_ONE = (MEM_AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [MEM_AW-1:0] ptr;
  logic [MEM_AW-1:0] base_q;
  logic [MEM_AW:0]   remaining;
  logic [MEM_AW:0]   count_q;

  logic [31:0] fifo_mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW:0]   occ;
  logic [IW+1:0] fill;

  logic inflight;
  logic pop_pending;

  logic stop_now;
  logic start_now;
  logic fifo_empty;
  logic rd_fire;
  logic last_rd;
  logic accept;
  logic wr_fire;
  logic pop_fire;

  // Control decode shared by the FSM and the datapath.
  always_comb begin
    stop_now   = trace_stop & (state != S_IDLE);
    start_now  = trace_start & ~stop_now & ((state == S_IDLE) | (state == S_DONE));
    fifo_empty = (occ == '0);
    // An outstanding read already owns a FIFO slot.
    fill       = {1'b0, occ} + {{(IW+1){1'b0}}, inflight};
    rd_fire    = (state == S_FETCH) & enable & (remaining != '0) & (fill < DEPTH_W);
    last_rd    = rd_fire & (remaining == CNT_ONE);
    accept     = enable & packet_request & ~fifo_empty & ~pop_pending;
    // A stop discards both the data landing this cycle and any pending pop.
    wr_fire    = inflight & ~stop_now;
    pop_fire   = pop_pending & ~stop_now;
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // FSM next-state logic; stop wins over everything else.
  always_comb begin
    state_nxt = state;
    if (stop_now) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (trace_start) state_nxt = (trace_count != '0) ? S_FETCH : S_DONE;
        end
        S_FETCH: begin
`ifdef TG_TRACE_LOOP_EN
          state_nxt = S_FETCH;
`else
          if (last_rd) state_nxt = S_DRAIN;
`endif
        end
        S_DRAIN: begin
          if (fifo_empty & ~inflight & ~pop_pending) state_nxt = S_DONE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // FSM and FIFO outputs.
  always_comb begin
    mem_rd_en        = rd_fire;
    mem_addr         = ptr;
    done             = (state == S_DONE);
    packet_out_valid = ~fifo_empty & ~pop_pending;
    packet_out       = fifo_mem[rd_idx];
  end

  // Read pointer and remaining count; latched on start, stepped per read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      base_q    <= '0;
      remaining <= '0;
      count_q   <= '0;
    end else if (start_now && trace_count != '0) begin
      ptr       <= trace_base;
      base_q    <= trace_base;
      remaining <= trace_count;
      count_q   <= trace_count;
    end else if (rd_fire) begin
`ifdef TG_TRACE_LOOP_EN
      if (last_rd) begin
        ptr       <= base_q;
        remaining <= count_q;
      end else begin
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end
`else
      ptr       <= ptr + 1'b1;
      remaining <= remaining - 1'b1;
`endif
    end
  end

  // In-flight read flag and handshake-to-pop delay.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight    <= 1'b0;
      pop_pending <= 1'b0;
    end else begin
      inflight    <= rd_fire & ~stop_now;
      pop_pending <= accept & ~stop_now;
    end
  end

  // FIFO indices and occupancy; simultaneous write and pop both apply.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else if (stop_now) begin
      wr_idx <= '0;
      rd_idx <= '0;
      occ    <= '0;
    end else begin
      if (wr_fire)  wr_idx <= wr_idx + 1'b1;
      if (pop_fire) rd_idx <= rd_idx + 1'b1;
      case ({wr_fire, pop_fire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // FIFO storage, cleared on reset so packet_out starts at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else if (wr_fire) begin
      fifo_mem[wr_idx] <= mem_rd_data;
    end
  end

  // Accepted-descriptor counter: cleared on start, saturating, held on stop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_count <= '0;
    end else if (start_now) begin
      pkt_count <= '0;
    end else if (pop_fire && pkt_count != 16'hFFFF) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_tg_trace_loader.sv
// Directed bench for tg_trace_loader with a behavioural 1-cycle trace memory.
`timescale 1ns/1ps
module tb_tg_trace_loader;

  localparam int MEM_AW = 10;
  localparam int DEPTH  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic              trace_start;
  logic              trace_stop;
  logic [MEM_AW-1:0] trace_base;
  logic [MEM_AW:0]   trace_count;
  logic              mem_rd_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rd_data;
  logic              packet_request;
  logic [31:0]       packet_out;
  logic              packet_out_valid;
  logic              done;
  logic [15:0]       pkt_count;

  int n_cmp = 0;
  int n_err = 0;
  int r0;

  logic [31:0]       mem [1024];
  logic [MEM_AW-1:0] addr_log [256];
  int                rd_cnt = 0;

  tg_trace_loader #(.MEM_AW(MEM_AW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .trace_start(trace_start), .trace_stop(trace_stop),
    .trace_base(trace_base), .trace_count(trace_count),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .packet_request(packet_request), .packet_out(packet_out),
    .packet_out_valid(packet_out_valid), .done(done), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_rd_en) begin
      mem_rd_data <= mem[mem_addr];
      if (rd_cnt < 256) addr_log[rd_cnt[7:0]] <= mem_addr;
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [MEM_AW-1:0] b, input logic [MEM_AW:0] c);
    trace_base  = b;
    trace_count = c;
    trace_start = 1'b1;
    tick();
    trace_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !packet_out_valid; i++) tick();
    chk({tag, "_valid"}, packet_out_valid, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    chk({tag, "_done"}, done, 1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[10'h010] = 32'hA;
    mem[10'h011] = 32'hB;
    mem[10'h012] = 32'hC;
    for (int i = 0; i < 8; i++) mem[10'h100 + i] = 32'h1000 + i;
    for (int i = 0; i < 5; i++) mem[10'h200 + i] = 32'h2000 + i;
    mem[10'h300] = 32'hDEADBEEF;

    reset = 1'b1; enable = 1'b1; trace_start = 1'b0; trace_stop = 1'b0;
    trace_base = '0; trace_count = '0; packet_request = 1'b0;
    tick(); tick();
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", packet_out_valid, 0);
    chk("rst_out", packet_out, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", pkt_count, 0);
    reset = 1'b0;
    tick();

`ifdef TG_TRACE_LOOP_EN
    packet_request = 1'b1;
    r0 = rd_cnt;
    start(10'h020, 2);
    for (int i = 0; i < 10; i++) tick();
    chk("loop_done", done, 0);
    chk("loop_a0", addr_log[r0],     10'h020);
    chk("loop_a1", addr_log[r0 + 1], 10'h021);
    chk("loop_a2", addr_log[r0 + 2], 10'h020);
    chk("loop_a3", addr_log[r0 + 3], 10'h021);
    trace_stop = 1'b1;
    tick();
    trace_stop = 1'b0;
    chk("loop_stop_done", done, 0);
    chk("loop_stop_rd", mem_rd_en, 0);
    chk("loop_stop_valid", packet_out_valid, 0);
`else
    // Basic three-word pass with the consumer always ready.
    packet_request = 1'b1;
    start(10'h010, 3);
    chk("t1_c1_rd", mem_rd_en, 1);
    chk("t1_c1_addr", mem_addr, 10'h010);
    tick();
    chk("t1_c2_addr", mem_addr, 10'h011);
    chk("t1_c2_valid", packet_out_valid, 0);
    tick();
    chk("t1_c3_addr", mem_addr, 10'h012);
    chk("t1_c3_valid", packet_out_valid, 1);
    chk("t1_c3_out", packet_out, 32'hA);
    tick();
    chk("t1_c4_valid", packet_out_valid, 0);
    chk("t1_c4_out", packet_out, 32'hA);
    tick();
    chk("t1_c5_rd", mem_rd_en, 0);
    chk("t1_c5_valid", packet_out_valid, 1);
    chk("t1_c5_out", packet_out, 32'hB);
    tick();
    chk("t1_c6_valid", packet_out_valid, 0);
    chk("t1_c6_out", packet_out, 32'hB);
    tick();
    chk("t1_c7_valid", packet_out_valid, 1);
    chk("t1_c7_out", packet_out, 32'hC);
    tick();
    chk("t1_c8_valid", packet_out_valid, 0);
    chk("t1_c8_out", packet_out, 32'hC);
    chk("t1_c8_done", done, 0);
    wait_done("t1", 4);
    chk("t1_cnt", pkt_count, 3);

    // Stop from DONE, then a zero-length start.
    trace_stop = 1'b1;
    tick();
    trace_stop = 1'b0;
    chk("t2_stop_done", done, 0);
    r0 = rd_cnt;
    start('0, 0);
    chk("t2_done", done, 1);
    tick(); tick(); tick();
    chk("t2_no_reads", rd_cnt - r0, 0);
    chk("t2_rd_en", mem_rd_en, 0);

    // Consumer stalled: FIFO fills to DEPTH, then reads resume one per pop.
    packet_request = 1'b0;
    r0 = rd_cnt;
    start(10'h100, 8);
    chk("t3_cnt_clr", pkt_count, 0);
    for (int i = 0; i < 8; i++) tick();
    chk("t3_reads4", rd_cnt - r0, 4);
    chk("t3_rd_en", mem_rd_en, 0);
    chk("t3_valid", packet_out_valid, 1);
    chk("t3_out0", packet_out, 32'h1000);
    packet_request = 1'b1;
    tick();
    chk("t3_pend_valid", packet_out_valid, 0);
    chk("t3_pend_rd", mem_rd_en, 0);
    tick();
    chk("t3_resume_rd", mem_rd_en, 1);
    chk("t3_resume_addr", mem_addr, 10'h104);
    for (int k = 1; k < 8; k++) begin
      wait_valid("t3", 8);
      chk("t3_word", packet_out, 32'h1000 + k);
      tick();
    end
    wait_done("t3", 6);
    chk("t3_reads8", rd_cnt - r0, 8);
    chk("t3_cnt", pkt_count, 8);

    // Address wrap at the top of the trace memory.
    r0 = rd_cnt;
    start(10'h3FE, 4);
    wait_done("t4", 30);
    chk("t4_reads", rd_cnt - r0, 4);
    chk("t4_a0", addr_log[r0],     10'h3FE);
    chk("t4_a1", addr_log[r0 + 1], 10'h3FF);
    chk("t4_a2", addr_log[r0 + 2], 10'h000);
    chk("t4_a3", addr_log[r0 + 3], 10'h001);
    chk("t4_cnt", pkt_count, 4);

    // Stop in the same cycle as a read; the returning word is dropped.
    packet_request = 1'b0;
    start(10'h200, 5);
    tick(); tick();
    chk("t5_rd_at_stop", mem_rd_en, 1);
    trace_stop = 1'b1;
    tick();
    trace_stop = 1'b0;
    chk("t5_valid_n1", packet_out_valid, 0);
    chk("t5_done_n1", done, 0);
    chk("t5_idle_rd", mem_rd_en, 0);
    tick();
    chk("t5_valid_n2", packet_out_valid, 0);
    tick();
    chk("t5_valid_n3", packet_out_valid, 0);
    r0 = rd_cnt;
    packet_request = 1'b1;
    start(10'h300, 1);
    wait_valid("t5", 6);
    chk("t5_word", packet_out, 32'hDEADBEEF);
    wait_done("t5", 6);
    chk("t5_cnt", pkt_count, 1);
    chk("t5_reads", rd_cnt - r0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
